// File: rtl/approx_mac_accum.sv
// approx_mac_accum: accumulates a frame of unsigned products into a saturating
// sum, then holds {sum, beat count, overflow} on a valid/ready result port until
// the consumer takes it. While a result is held, no new beats are accepted.
module approx_mac_accum #(
   parameter int N         = 8,
   parameter int FRAME_LEN = 16,
   parameter int ACC_W     = 20,
   localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*N-1:0]     in_prod,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_ovf
);

   typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               oovf_q, oovf_d;

   // One spare bit on the add catches the carry-out that signals saturation.
   logic [ACC_W:0]     sum_ext;
   logic               clamp;
   logic [ACC_W-1:0]   acc_nx;
   logic [CNT_W-1:0]   cnt_nx;
   logic               accept;
   logic               close;

   // Datapath terms for the beat presented this cycle.
   always_comb begin
      sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 2*N){1'b0}}, in_prod};
      clamp   = sum_ext[ACC_W];
      acc_nx  = clamp ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      cnt_nx  = cnt_q + 1'b1;
      accept  = (state_q == S_ACCUM) && in_valid;
      close   = in_last || (cnt_nx == FRAME_CNT);
   end

   // Next-state logic; handshake outputs depend on state only.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      sum_d     = sum_q;
      count_d   = count_q;
      oovf_d    = oovf_q;
      in_ready  = (state_q == S_ACCUM);
      out_valid = (state_q == S_HOLD);
      case (state_q)
         S_ACCUM: begin
            if (accept) begin
               if (close) begin
                  sum_d   = acc_nx;
                  count_d = cnt_nx;
                  oovf_d  = ovf_q | clamp;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = S_HOLD;
               end else begin
                  acc_d   = acc_nx;
                  cnt_d   = cnt_nx;
                  ovf_d   = ovf_q | clamp;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) state_d = S_ACCUM;
         end
         default: state_d = S_ACCUM;
      endcase
   end

   // State registers; reset discards any partial frame or held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         oovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         oovf_q  <= oovf_d;
      end
   end

   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign out_ovf   = oovf_q;

endmodule

// File: tb/tb_approx_mac_accum.sv
// Bench for approx_mac_accum: two instances (ACC_W=20 and ACC_W=16) share one
// input stream; a frame-level model (total of beats, clamped once) predicts
// each result.
module tb_approx_mac_accum;
   localparam int N  = 8;
   localparam int FL = 16;
   localparam int WA = 20;
   localparam int WB = 16;
   localparam int CW = $clog2(FL + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic [2*N-1:0]  in_prod = '0;
   logic            in_last = 1'b0;
   logic            out_ready = 1'b0;

   logic            rdy_a, vld_a, ovf_a, rdy_b, vld_b, ovf_b;
   logic [WA-1:0]   sum_a;
   logic [WB-1:0]   sum_b;
   logic [CW-1:0]   cnt_a, cnt_b;

   approx_mac_accum #(.N(N), .FRAME_LEN(FL), .ACC_W(WA)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
      .in_prod(in_prod), .in_last(in_last), .out_valid(vld_a),
      .out_ready(out_ready), .out_sum(sum_a), .out_count(cnt_a), .out_ovf(ovf_a));

   approx_mac_accum #(.N(N), .FRAME_LEN(FL), .ACC_W(WB)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
      .in_prod(in_prod), .in_last(in_last), .out_valid(vld_b),
      .out_ready(out_ready), .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b));

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_err = 0;
   longint m_total = 0;   // sum of beats accepted so far in the open frame
   int     m_cnt = 0;
   longint e_total = 0;   // unclamped total of the last closed frame
   int     e_cnt = 0;
   bit     holding = 1'b0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic longint ovf(input longint v, input int w);
      return (v > (longint'(1) << w) - 1) ? 1 : 0;
   endfunction

   task automatic check_result(input string tag);
      chk({tag, ".vld_a"}, vld_a, 1);
      chk({tag, ".vld_b"}, vld_b, 1);
      chk({tag, ".rdy_a"}, rdy_a, 0);
      chk({tag, ".rdy_b"}, rdy_b, 0);
      chk({tag, ".sum_a"}, sum_a, sat(e_total, WA));
      chk({tag, ".sum_b"}, sum_b, sat(e_total, WB));
      chk({tag, ".ovf_a"}, ovf_a, ovf(e_total, WA));
      chk({tag, ".ovf_b"}, ovf_b, ovf(e_total, WB));
      chk({tag, ".cnt_a"}, cnt_a, e_cnt);
      chk({tag, ".cnt_b"}, cnt_b, e_cnt);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".rdy_a"}, rdy_a, 1);
      chk({tag, ".rdy_b"}, rdy_b, 1);
      chk({tag, ".vld_a"}, vld_a, 0);
      chk({tag, ".vld_b"}, vld_b, 0);
      chk({tag, ".sum_a"}, sum_a, 0);
      chk({tag, ".sum_b"}, sum_b, 0);
      chk({tag, ".cnt_a"}, cnt_a, 0);
      chk({tag, ".ovf_a"}, ovf_a, 0);
   endtask

   // Drive garbage on the data inputs while nothing is being offered.
   task automatic idle_inputs();
      in_valid = 1'b0;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic do_reset(input int cycles, input logic iv);
      rst = 1'b1;
      in_valid = iv;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_inputs();
      m_total = 0;
      m_cnt   = 0;
      holding = 1'b0;
   endtask

   // Offer one beat; inputs change 1 time unit after a rising edge.
   task automatic beat(input logic [15:0] p, input logic l);
      int guard = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      while (!rdy_a && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!rdy_a) begin
         chk("beat_ready_timeout", 0, 1);
         idle_inputs();
      end else begin
         @(posedge clk); #1;
         idle_inputs();
         m_total += p;
         m_cnt++;
         if (l || m_cnt == FL) begin
            e_total = m_total;
            e_cnt   = m_cnt;
            m_total = 0;
            m_cnt   = 0;
            holding = 1'b1;
            check_result("close");
         end else begin
            chk("open.vld_a", vld_a, 0);
            chk("open.rdy_b", rdy_b, 1);
         end
      end
   endtask

   // Hold the result for 'stall' cycles (beats offered meanwhile must be
   // ignored), then hand it off.
   task automatic drain(input int stall);
      for (int i = 0; i < stall; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_prod   = 16'($urandom);
         in_last   = 1'($urandom);
         @(posedge clk); #1;
         check_result("stall");
      end
      idle_inputs();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("drain.vld_a", vld_a, 0);
      chk("drain.vld_b", vld_b, 0);
      chk("drain.rdy_a", rdy_a, 1);
      chk("drain.keep_sum", sum_a, sat(e_total, WA));
      holding = 1'b0;
   endtask

   initial begin
      idle_inputs();

      // Reset with in_valid high throughout.
      do_reset(3, 1'b1);
      check_reset_state("reset");

      // Frame closed by in_last.
      beat(16'h1000, 1'b0);
      beat(16'h2000, 1'b0);
      beat(16'h0300, 1'b1);
      chk("f1.sum", sum_a, 32'h3300);
      drain(0);

      // Full frame without in_last; 16-bit instance saturates.
      for (int i = 0; i < FL; i++) beat(16'hE100, 1'b0);
      chk("full.sum", sum_a, 32'hE1000);
      chk("full.cnt", cnt_a, FL);
      chk("full.satb", sum_b, 32'hFFFF);
      // Backpressure for 10 cycles.
      drain(10);

      // Saturation then a clean frame clearing the flag.
      beat(16'hF000, 1'b0);
      beat(16'h2000, 1'b1);
      chk("sat.ovf_b", ovf_b, 1);
      drain(1);
      beat(16'h0100, 1'b1);
      chk("sat2.ovf_b", ovf_b, 0);
      drain(0);

      // Idle gap inside a frame with garbage on the data inputs.
      beat(16'h0010, 1'b0);
      repeat (3) begin idle_inputs(); @(posedge clk); #1; end
      beat(16'h0020, 1'b1);
      drain(2);

      // Reset mid-frame discards the partial sum.
      beat(16'h0100, 1'b0);
      beat(16'h0100, 1'b0);
      do_reset(1, 1'b0);
      check_reset_state("rst_mid");
      beat(16'h0200, 1'b1);
      chk("rst_mid.cnt", cnt_a, 1);
      drain(0);

      // Reset while holding a result.
      beat(16'h0055, 1'b1);
      do_reset(1, 1'b0);
      check_reset_state("rst_hold");

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         while (!holding) begin
            logic [15:0] p;
            p = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
            if ($urandom_range(3) == 0) begin
               idle_inputs(); @(posedge clk); #1;
            end
            beat(p, ($urandom_range(5) == 0));
         end
         drain($urandom_range(3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
